// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared constants for the fetch path: address and instruction widths,
//   the width of a 4-instruction fetch line, and a helper that maps a
//   byte PC onto its 16-byte-aligned line address.
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INSN_LEN = 32;
    localparam int LINE_LEN = 4 * INSN_LEN;

    // A line holds four 32-bit instructions, so the low four address bits
    // select within the line and are zeroed for the memory request.
    function automatic logic [ADDR_LEN-1:0] line_addr(input logic [ADDR_LEN-1:0] addr);
        return {addr[ADDR_LEN-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   - clock
//     reset - asynchronous active-high clear
//     inc   - count enable for this cycle
//     out   - current count (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] out
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign out = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Drives the instruction-memory request/response handshake for the fetch
//   stage, keeping exactly one request outstanding, and presents the
//   returned line to the fetch select logic. A misprediction redirect can
//   arrive in any state; a response belonging to an abandoned request is
//   swallowed in DROP.
//   Ports:
//     clk, reset         - clock, asynchronous active-high reset
//     npc                - next PC for the current pc (taken when decode accepts)
//     stall_dc           - decode cannot accept the presented line
//     prmiss, jmpaddr    - redirect strobe and target
//     imem_req/addr/gnt  - request handshake (line-aligned address)
//     imem_rvalid/rdata  - response strobe and 4-instruction line
//     pc, idata          - current fetch PC and its registered line
//     fetch_valid        - idata corresponds to pc
//     bubble_cnt         - saturating count of cycles with fetch_valid=0
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] npc,
    input  logic                stall_dc,
    input  logic                prmiss,
    input  logic [ADDR_LEN-1:0] jmpaddr,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [LINE_LEN-1:0] imem_rdata,
    output logic [ADDR_LEN-1:0] pc,
    output logic [LINE_LEN-1:0] idata,
    output logic                fetch_valid,
    output logic [CNT_W-1:0]    bubble_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_VALID,
        ST_DROP
    } fetch_state_t;

    fetch_state_t        state_reg, state_next;
    logic [ADDR_LEN-1:0] pc_reg, pc_next;
    logic [LINE_LEN-1:0] idata_reg, idata_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            idata_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            idata_reg <= idata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        idata_next = idata_reg;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                // A grant commits the request; if a redirect arrives with
                // it, the response must still be absorbed in DROP.
                // Without a grant the request is simply withdrawn for a cycle.
                if (imem_gnt) begin
                    state_next = prmiss ? ST_DROP : ST_WAIT;
                end else if (prmiss) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (prmiss) begin
                    state_next = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    idata_next = imem_rdata;
                    state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                if (prmiss) begin
                    state_next = ST_REQ;
                end else if (!stall_dc) begin
                    pc_next    = npc;
                    state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The redirect target overrides any other pc update.
        if (prmiss) begin
            pc_next = jmpaddr;
        end
    end

    assign imem_req    = (state_reg == ST_REQ);
    assign imem_addr   = line_addr(pc_reg);
    assign fetch_valid = (state_reg == ST_VALID);
    assign pc          = pc_reg;
    assign idata       = idata_reg;

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!fetch_valid),
        .out   (bubble_cnt)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed cycle table, hand-written reset / saturation sequences and a
//   randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic         clk;
    logic         reset;
    logic [31:0]  npc;
    logic         stall_dc;
    logic         prmiss;
    logic [31:0]  jmpaddr;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [127:0] imem_rdata;
    logic [31:0]  pc;
    logic [127:0] idata;
    logic         fetch_valid;
    logic [15:0]  bubble_cnt;

    int vectors;
    int miscompares;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .npc         (npc),
        .stall_dc    (stall_dc),
        .prmiss      (prmiss),
        .jmpaddr     (jmpaddr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .idata       (idata),
        .fetch_valid (fetch_valid),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D2 = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;
    localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D5 = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
    localparam logic [127:0] D6 = 128'hCAFECAFE_CAFECAFE_CAFECAFE_CAFECAFE;

    typedef struct {
        logic [31:0]  npc;
        logic         stall;
        logic         prmiss;
        logic [31:0]  jmp;
        logic         gnt;
        logic         rvalid;
        logic [127:0] rdata;
        logic         e_req;
        logic [31:0]  e_pc;
        logic         e_valid;
        logic [127:0] e_idata;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] n, input logic st, input logic pm,
                                input logic [31:0] j, input logic g, input logic rv,
                                input logic [127:0] rd, input logic er,
                                input logic [31:0] ep, input logic ev,
                                input logic [127:0] ei);
        vec_t v;
        v.npc = n; v.stall = st; v.prmiss = pm; v.jmp = j; v.gnt = g;
        v.rvalid = rv; v.rdata = rd; v.e_req = er; v.e_pc = ep;
        v.e_valid = ev; v.e_idata = ei;
        return v;
    endfunction

    task automatic drive(input logic [31:0] n, input logic st, input logic pm,
                         input logic [31:0] j, input logic g, input logic rv,
                         input logic [127:0] rd);
        npc = n; stall_dc = st; prmiss = pm; jmpaddr = j;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    endtask

    task automatic check(input string name, input bit verbose, input logic e_req,
                         input logic [31:0] e_pc, input logic e_valid,
                         input logic [127:0] e_idata, input logic [15:0] e_bub);
        logic [31:0] e_addr;
        bit bad;
        e_addr = {e_pc[31:4], 4'b0000};
        vectors++;
        bad = $isunknown({imem_req, imem_addr, pc, idata, fetch_valid, bubble_cnt})
              || imem_req !== e_req || imem_addr !== e_addr || pc !== e_pc
              || fetch_valid !== e_valid || idata !== e_idata || bubble_cnt !== e_bub;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got req=%0b addr=%h pc=%h valid=%0b idata=%h bub=%h ; want req=%0b addr=%h pc=%h valid=%0b idata=%h bub=%h",
                     name, imem_req, imem_addr, pc, fetch_valid, idata, bubble_cnt,
                     e_req, e_addr, e_pc, e_valid, e_idata, e_bub);
        end else if (verbose) begin
            $display("%s: req=%0b addr=%h pc=%h valid=%0b bub=%0d ok",
                     name, imem_req, imem_addr, pc, fetch_valid, bubble_cnt);
        end
    endtask

    // Holds reset for two cycles, checks the reset state, and releases it on
    // a falling edge so the next stimulus lands before the first active edge.
    task automatic do_reset();
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 1'b1, 1'b0, 32'h0, 1'b0, 128'h0, 16'h0);
        reset = 1'b0;
    endtask

    vec_t tbl[25];
    logic [15:0] exp_bub;

    // Reference model: request / in-flight / line-held view of the fetcher.
    bit           m_gap, m_req, m_inflight, m_keep, m_valid;
    logic [31:0]  m_pc;
    logic [127:0] m_idata;
    logic [15:0]  m_bub;

    task automatic model_step();
        bit           n_gap, n_req, n_inflight, n_keep, n_valid;
        logic [31:0]  n_pc;
        logic [127:0] n_idata;
        n_gap = m_gap; n_req = m_req; n_inflight = m_inflight; n_keep = m_keep;
        n_valid = m_valid; n_pc = m_pc; n_idata = m_idata;
        if (m_gap) begin
            n_gap = 0; n_req = 1;
        end
        if (m_req) begin
            if (imem_gnt) begin
                n_req = 0; n_inflight = 1; n_keep = !prmiss;
            end else if (prmiss) begin
                n_req = 0; n_gap = 1;
            end
        end
        if (m_inflight) begin
            if (imem_rvalid) begin
                n_inflight = 0;
                if (m_keep && !prmiss) begin
                    n_valid = 1; n_idata = imem_rdata;
                end else begin
                    n_req = 1;
                end
            end else if (prmiss) begin
                n_keep = 0;
            end
        end
        if (m_valid) begin
            if (prmiss) begin
                n_valid = 0; n_req = 1;
            end else if (!stall_dc) begin
                n_pc = npc; n_valid = 0; n_req = 1;
            end
        end
        if (prmiss) n_pc = jmpaddr;
        if (!m_valid && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
        m_gap = n_gap; m_req = n_req; m_inflight = n_inflight; m_keep = n_keep;
        m_valid = n_valid; m_pc = n_pc; m_idata = n_idata;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;

        //               npc   st pm jmp          g  rv rdata | req pc          v  idata
        tbl[0]  = mk(32'h0,  0, 0, 32'h0,        0, 0, '0,  0, 32'h0,        0, '0);
        tbl[1]  = mk(32'h0,  0, 0, 32'h0,        1, 0, '0,  1, 32'h0,        0, '0);
        tbl[2]  = mk(32'h0,  0, 0, 32'h0,        0, 0, '0,  0, 32'h0,        0, '0);
        tbl[3]  = mk(32'h0,  0, 0, 32'h0,        0, 1, D1,  0, 32'h0,        0, '0);
        tbl[4]  = mk(32'h18, 1, 0, 32'h0,        0, 0, '0,  0, 32'h0,        1, D1);
        tbl[5]  = mk(32'h18, 1, 0, 32'h0,        0, 0, '0,  0, 32'h0,        1, D1);
        tbl[6]  = mk(32'h18, 1, 0, 32'h0,        0, 0, '0,  0, 32'h0,        1, D1);
        tbl[7]  = mk(32'h18, 0, 0, 32'h0,        0, 0, '0,  0, 32'h0,        1, D1);
        tbl[8]  = mk(32'h0,  0, 0, 32'h0,        1, 0, '0,  1, 32'h18,       0, D1);
        tbl[9]  = mk(32'h0,  0, 1, 32'h400,      0, 0, '0,  0, 32'h18,       0, D1);
        tbl[10] = mk(32'h0,  0, 0, 32'h0,        0, 1, D2,  0, 32'h400,      0, D1);
        tbl[11] = mk(32'h0,  0, 1, 32'h400,      0, 0, '0,  1, 32'h400,      0, D1);
        tbl[12] = mk(32'h0,  0, 0, 32'h0,        0, 0, '0,  0, 32'h400,      0, D1);
        tbl[13] = mk(32'h0,  0, 0, 32'h0,        1, 0, '0,  1, 32'h400,      0, D1);
        tbl[14] = mk(32'h0,  0, 0, 32'h0,        0, 1, D3,  0, 32'h400,      0, D1);
        tbl[15] = mk(32'h0,  0, 1, 32'hFFFFFFF8, 0, 0, '0,  0, 32'h400,      1, D3);
        tbl[16] = mk(32'h0,  0, 0, 32'h0,        1, 0, '0,  1, 32'hFFFFFFF8, 0, D3);
        tbl[17] = mk(32'h0,  0, 0, 32'h0,        0, 1, D4,  0, 32'hFFFFFFF8, 0, D3);
        tbl[18] = mk(32'h0,  0, 0, 32'h0,        0, 0, '0,  0, 32'hFFFFFFF8, 1, D4);
        tbl[19] = mk(32'h0,  0, 1, 32'h100,      1, 0, '0,  1, 32'h0,        0, D4);
        tbl[20] = mk(32'h0,  0, 1, 32'h200,      0, 0, '0,  0, 32'h100,      0, D4);
        tbl[21] = mk(32'h0,  0, 0, 32'h0,        0, 1, D5,  0, 32'h200,      0, D4);
        tbl[22] = mk(32'h0,  0, 0, 32'h0,        1, 0, '0,  1, 32'h200,      0, D4);
        tbl[23] = mk(32'h0,  0, 1, 32'h300,      0, 1, D6,  0, 32'h200,      0, D4);
        tbl[24] = mk(32'h0,  0, 0, 32'h0,        0, 0, '0,  1, 32'h300,      0, D4);

        // ---------------- directed table ----------------
        do_reset();
        exp_bub = 16'h0;
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].npc, tbl[i].stall, tbl[i].prmiss, tbl[i].jmp,
                  tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
            check($sformatf("vec%0d", i), 1'b1, tbl[i].e_req, tbl[i].e_pc,
                  tbl[i].e_valid, tbl[i].e_idata, exp_bub);
            if (!tbl[i].e_valid) exp_bub = exp_bub + 16'd1;
            @(negedge clk);
        end

        // ---------------- reset mid-request ----------------
        do_reset();
        drive(32'h0, 0, 0, 32'h0, 0, 0, '0);
        @(negedge clk);
        check("pre_rst_req", 1'b1, 1'b1, 32'h0, 1'b0, 128'h0, 16'd1);
        reset = 1'b1;
        #1;
        check("async_rst", 1'b1, 1'b0, 32'h0, 1'b0, 128'h0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0, 0, 0, 32'h0, 0, 1, D1);
        check("rst_idle", 1'b1, 1'b0, 32'h0, 1'b0, 128'h0, 16'd0);
        @(negedge clk);
        check("rst_req_a", 1'b1, 1'b1, 32'h0, 1'b0, 128'h0, 16'd1);
        @(negedge clk);
        check("rst_req_b", 1'b1, 1'b1, 32'h0, 1'b0, 128'h0, 16'd2);
        drive(32'h0, 0, 0, 32'h0, 1, 1, D1);
        @(negedge clk);
        check("rst_wait", 1'b1, 1'b0, 32'h0, 1'b0, 128'h0, 16'd3);
        drive(32'h0, 1, 0, 32'h0, 0, 1, D2);
        @(negedge clk);
        check("rst_valid", 1'b1, 1'b0, 32'h0, 1'b1, D2, 16'd4);

        // ---------------- randomized vs model ----------------
        do_reset();
        m_gap = 1; m_req = 0; m_inflight = 0; m_keep = 0; m_valid = 0;
        m_pc = 32'h0; m_idata = '0; m_bub = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  {$urandom, $urandom, $urandom, $urandom});
            check("rand", 1'b0, m_req, m_pc, m_valid, m_idata, m_bub);
            model_step();
            @(negedge clk);
        end

        // ---------------- bubble counter saturation ----------------
        do_reset();
        drive(32'h0, 0, 0, 32'h0, 0, 0, '0);
        repeat (65534) @(negedge clk);
        check("sat_near", 1'b1, 1'b1, 32'h0, 1'b0, 128'h0, 16'hFFFE);
        repeat (7) @(negedge clk);
        check("sat_hold", 1'b1, 1'b1, 32'h0, 1'b0, 128'h0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
